// File: rtl/uart_buffered_loopback_if.sv
// uart_buffered_loopback_if: serial lines, per-frame configuration and status of the buffered UART echo engine
interface uart_buffered_loopback_if #(
  parameter int CLOCK_DIVIDER_WIDTH = 7,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic serial_i;
  logic serial_o;
  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i;
  logic two_stop_bits_i;
  logic parity_bit_i;
  logic parity_even_i;
  logic echo_enable_i;
  logic clear_errors_i;
  logic [CW-1:0] fifo_count_o;
  logic write_busy_o;
  logic overrun_o;
  logic frame_error_o;
  logic parity_error_o;
  modport master (
    output serial_i, clock_divider_i, two_stop_bits_i, parity_bit_i, parity_even_i,
           echo_enable_i, clear_errors_i,
    input serial_o, fifo_count_o, write_busy_o, overrun_o, frame_error_o, parity_error_o
  );
  modport slave (
    input serial_i, clock_divider_i, two_stop_bits_i, parity_bit_i, parity_even_i,
          echo_enable_i, clear_errors_i,
    output serial_o, fifo_count_o, write_busy_o, overrun_o, frame_error_o, parity_error_o
  );
endinterface

// File: rtl/uart_buffered_loopback.sv
// uart_buffered_loopback: UART receiver feeding a FIFO that is re-serialised by a UART transmitter
module uart_buffered_loopback #(
  parameter int DATA_WIDTH = 8,
  parameter int CLOCK_DIVIDER_WIDTH = 7,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clock_i,
  input logic reset_i,
  uart_buffered_loopback_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int CDW = CLOCK_DIVIDER_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DW);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP1, T_STOP2} tx_state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic rx_line;
  rx_state_t rx_state_q, rx_state_d;
  logic [CDW-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic rx_par_en_q, rx_par_en_d, rx_even_q, rx_even_d, rx_par_q, rx_par_d, rx_valid_q, rx_valid_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic frame_set, parity_set;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic push_req, push, pop, full, overrun_set;

  tx_state_t tx_state_q, tx_state_d;
  logic [CDW-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic tx_two_q, tx_two_d, tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d, serial_q, serial_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d, pop_data;
  logic busy_q, busy_d, overrun_q, overrun_d, frame_q, frame_d, parity_q, parity_d;

  assign rx_line = sync_q[SYNC_STAGES-1];
  assign pop_data = mem_q[rd_q];

  // Shift the asynchronous line through the synchroniser chain
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], bus.serial_i};

  // Receiver: mid-bit sampling, config captured at start-bit detection
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_cnt_q;
    rx_div_d = rx_div_q;
    rx_par_en_d = rx_par_en_q;
    rx_even_d = rx_even_q;
    rx_par_d = rx_par_q;
    rx_bit_d = rx_bit_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    frame_set = 1'b0;
    parity_set = 1'b0;
    if (rx_state_q != R_IDLE && rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
    else
      case (rx_state_q)
        R_IDLE: if (!rx_line) begin
          rx_cnt_d = bus.clock_divider_i >> 1;
          rx_div_d = bus.clock_divider_i;
          rx_par_en_d = bus.parity_bit_i;
          rx_even_d = bus.parity_even_i;
          rx_state_d = R_START;
        end
        R_START: begin
          rx_cnt_d = rx_div_q;
          rx_bit_d = '0;
          rx_state_d = rx_line ? R_IDLE : R_DATA;
        end
        R_DATA: begin
          rx_data_d = {rx_line, rx_data_q[DW-1:1]};
          rx_cnt_d = rx_div_q;
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == BW'(DW - 1)) rx_state_d = rx_par_en_q ? R_PARITY : R_STOP;
        end
        R_PARITY: begin
          rx_par_d = rx_line;
          rx_cnt_d = rx_div_q;
          rx_state_d = R_STOP;
        end
        R_STOP: begin
          frame_set = !rx_line;
          parity_set = rx_line && rx_par_en_q && (rx_par_q != (rx_even_q ? ^rx_data_q : ~^rx_data_q));
          rx_valid_d = rx_line && !parity_set;
          rx_state_d = R_IDLE;
        end
        default: rx_state_d = R_IDLE;
      endcase
  end

  // FIFO bookkeeping: a push into a full FIFO survives only if a pop frees a slot
  always_comb begin
    push_req = rx_valid_q && bus.echo_enable_i;
    pop = (tx_state_q == T_IDLE) && (count_q != '0);
    full = count_q == CW'(FIFO_DEPTH);
    push = push_req && (!full || pop);
    overrun_set = push_req && !push;
    count_d = count_q + CW'(push) - CW'(pop);
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
  end

  // Transmitter: config captured at pop, idle state forces exactly one idle clock between frames
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q;
    tx_two_d = tx_two_q;
    tx_par_en_d = tx_par_en_q;
    tx_par_d = tx_par_q;
    tx_bit_d = tx_bit_q;
    tx_shift_d = tx_shift_q;
    serial_d = serial_q;
    if (tx_state_q == T_IDLE) begin
      serial_d = 1'b1;
      if (pop) begin
        tx_div_d = bus.clock_divider_i;
        tx_cnt_d = bus.clock_divider_i;
        tx_two_d = bus.two_stop_bits_i;
        tx_par_en_d = bus.parity_bit_i;
        tx_par_d = bus.parity_even_i ? ^pop_data : ~^pop_data;
        tx_shift_d = pop_data;
        serial_d = 1'b0;
        tx_state_d = T_START;
      end
    end else if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
    else begin
      tx_cnt_d = tx_div_q;
      case (tx_state_q)
        T_START: begin
          serial_d = tx_shift_q[0];
          tx_bit_d = '0;
          tx_state_d = T_DATA;
        end
        T_DATA: if (tx_bit_q == BW'(DW - 1)) begin
          serial_d = tx_par_en_q ? tx_par_q : 1'b1;
          tx_state_d = tx_par_en_q ? T_PARITY : T_STOP1;
        end else begin
          serial_d = tx_shift_q[1];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d = tx_bit_q + 1'b1;
        end
        T_PARITY: begin
          serial_d = 1'b1;
          tx_state_d = T_STOP1;
        end
        T_STOP1: tx_state_d = tx_two_q ? T_STOP2 : T_IDLE;
        default: tx_state_d = T_IDLE;
      endcase
    end
  end

  // Registered status; a set outranks a simultaneous clear
  always_comb begin
    busy_d = (tx_state_d != T_IDLE) || (count_d != '0);
    overrun_d = overrun_set || (overrun_q && !bus.clear_errors_i);
    frame_d = frame_set || (frame_q && !bus.clear_errors_i);
    parity_d = parity_set || (parity_q && !bus.clear_errors_i);
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clock_i) if (push) mem_q[wr_q] <= rx_data_q;

  // State registers; reset forces the TX line idle immediately
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      sync_q <= '1;
      rx_state_q <= R_IDLE;
      rx_cnt_q <= '0;
      rx_div_q <= '0;
      rx_par_en_q <= 1'b0;
      rx_even_q <= 1'b0;
      rx_par_q <= 1'b0;
      rx_bit_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      tx_state_q <= T_IDLE;
      tx_cnt_q <= '0;
      tx_div_q <= '0;
      tx_two_q <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_par_q <= 1'b0;
      tx_bit_q <= '0;
      tx_shift_q <= '0;
      serial_q <= 1'b1;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
      frame_q <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d;
      rx_par_en_q <= rx_par_en_d;
      rx_even_q <= rx_even_d;
      rx_par_q <= rx_par_d;
      rx_bit_q <= rx_bit_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d;
      tx_two_q <= tx_two_d;
      tx_par_en_q <= tx_par_en_d;
      tx_par_q <= tx_par_d;
      tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      serial_q <= serial_d;
      busy_q <= busy_d;
      overrun_q <= overrun_d;
      frame_q <= frame_d;
      parity_q <= parity_d;
    end

  assign bus.serial_o = serial_q;
  assign bus.fifo_count_o = count_q;
  assign bus.write_busy_o = busy_q;
  assign bus.overrun_o = overrun_q;
  assign bus.frame_error_o = frame_q;
  assign bus.parity_error_o = parity_q;
endmodule

// File: tb/tb_uart_buffered_loopback.sv
// tb_uart_buffered_loopback: random and directed UART frames, echoed stream decoded and scoreboarded
module tb_uart_buffered_loopback;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_buffered_loopback_if #(.CLOCK_DIVIDER_WIDTH(7), .FIFO_DEPTH(DEPTH)) u_if ();
  uart_buffered_loopback #(.DATA_WIDTH(8), .CLOCK_DIVIDER_WIDTH(7), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus(u_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_sub_rx = 0;
  logic [7:0] exp_q[$];
  int mon_div = 87;
  bit mon_par = 0, mon_even = 0, mon_two = 0, mon_ignore = 0, mon_busy = 0, sub_mode = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit par_of(logic [7:0] d, bit even);
    return even ? ^d : ~^d;
  endfunction

  task automatic set_cfg(int div, bit par, bit even, bit two);
    u_if.clock_divider_i = 7'(div);
    u_if.parity_bit_i = par;
    u_if.parity_even_i = even;
    u_if.two_stop_bits_i = two;
    mon_div = div;
    mon_par = par;
    mon_even = even;
    mon_two = two;
  endtask

  // RX stimulus; a frame the spec calls good (and echo on) is expected back on serial_o
  task automatic send_frame(logic [7:0] d, bit bad_par, bit bad_stop);
    int p;
    p = mon_div + 1;
    if (!bad_stop && !(mon_par && bad_par) && u_if.echo_enable_i) exp_q.push_back(d);
    u_if.serial_i = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.serial_i = d[i];
      repeat (p) @(negedge clk);
    end
    if (mon_par) begin
      u_if.serial_i = par_of(d, mon_even) ^ bad_par;
      repeat (p) @(negedge clk);
    end
    u_if.serial_i = !bad_stop;
    repeat (p) @(negedge clk);
    u_if.serial_i = 1'b1;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    u_if.clear_errors_i = 1'b1;
    @(negedge clk);
    u_if.clear_errors_i = 1'b0;
    check("clear_overrun", u_if.overrun_o, 0);
    check("clear_frame", u_if.frame_error_o, 0);
    check("clear_parity", u_if.parity_error_o, 0);
  endtask

  task automatic drain();
    int stable, t;
    stable = 0;
    t = 0;
    repeat (12) @(negedge clk);
    while (stable < 4 && t < 20000) begin
      @(negedge clk);
      t++;
      stable = (!u_if.write_busy_o && !mon_busy) ? stable + 1 : 0;
    end
    check("drain_done", stable >= 4, 1);
    if (!sub_mode) check("exp_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: records each serial_o frame at negedges and decodes it at mid-bit
  bit s[$];
  int lp, lpar, leven, ltwo, run, idx;
  bit busy_all, ign;
  logic [7:0] d;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && u_if.serial_o === 1'b0) begin
        lp = mon_div + 1;
        lpar = mon_par;
        leven = mon_even;
        ltwo = mon_two;
        ign = mon_ignore;
        busy_all = u_if.write_busy_o;
        mon_busy = 1'b1;
        s.delete();
        s.push_back(1'b0);
        for (int i = 1; i < (10 + lpar + ltwo) * lp; i++) begin
          @(negedge clk);
          s.push_back(u_if.serial_o);
          busy_all &= u_if.write_busy_o;
        end
        mon_busy = 1'b0;
        if (!(ign || mon_ignore)) begin
          d = '0;
          for (int k = 0; k < 8; k++) d[k] = s[(1 + k) * lp + lp / 2];
          idx = 9;
          if (lpar != 0) begin
            check("tx_parity", s[9 * lp + lp / 2], par_of(d, leven != 0));
            idx = 10;
          end
          check("tx_stop1", s[idx * lp + lp / 2], 1);
          if (ltwo != 0) check("tx_stop2", s[(idx + 1) * lp + lp / 2], 1);
          check("busy_during_tx", busy_all, 1);
          run = 0;
          while (run < s.size() && s[run] == 1'b0) run++;
          if (d[0]) check("tx_start_len", run, lp);
          if (sub_mode) begin
            while (exp_q.size() > 0 && exp_q[0] !== d) void'(exp_q.pop_front());
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL tx_order: got %02h which is not in the remaining expected stream", d);
            end else begin
              void'(exp_q.pop_front());
              n_sub_rx++;
            end
          end else if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_unexpected: got %02h expected no frame", d);
          end else check("tx_data", d, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] rd;
    bit bp, bs;
    int t;
    u_if.serial_i = 1'b1;
    u_if.echo_enable_i = 1'b1;
    u_if.clear_errors_i = 1'b0;
    set_cfg(87, 0, 0, 0);
    repeat (4) @(negedge clk);
    check("rst_serial_o", u_if.serial_o, 1);
    check("rst_count", u_if.fifo_count_o, 0);
    check("rst_busy", u_if.write_busy_o, 0);
    check("rst_overrun", u_if.overrun_o, 0);
    check("rst_frame", u_if.frame_error_o, 0);
    check("rst_parity", u_if.parity_error_o, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 div=87 echo with latency check
    fork
      send_frame(8'hA5, 0, 0);
      begin
        t = 0;
        while (u_if.fifo_count_o != 1 && t < 3000) begin
          @(negedge clk);
          t++;
        end
        check("count_rises", u_if.fifo_count_o, 1);
        check("busy_when_queued", u_if.write_busy_o, 1);
        @(negedge clk);
        check("tx_start_latency", u_if.serial_o, 0);
        check("count_after_pop", u_if.fifo_count_o, 0);
      end
    join
    drain();

    // 8E1 parity error
    set_cfg(15, 1, 1, 0);
    send_frame(8'h03, 1, 0);
    repeat (6) @(negedge clk);
    check("par_flag", u_if.parity_error_o, 1);
    check("par_frame_flag", u_if.frame_error_o, 0);
    check("par_count", u_if.fifo_count_o, 0);
    check("par_busy", u_if.write_busy_o, 0);
    clear_flags();

    // 8N1 frame error
    set_cfg(15, 0, 0, 0);
    send_frame(8'h5A, 0, 1);
    repeat (6) @(negedge clk);
    check("frm_flag", u_if.frame_error_o, 1);
    check("frm_par_flag", u_if.parity_error_o, 0);
    check("frm_count", u_if.fifo_count_o, 0);
    check("frm_serial_o", u_if.serial_o, 1);
    repeat (40) @(negedge clk);
    clear_flags();

    // start-bit glitch then a normal frame
    set_cfg(87, 0, 0, 0);
    u_if.serial_i = 1'b0;
    repeat (30) @(negedge clk);
    u_if.serial_i = 1'b1;
    repeat (150) @(negedge clk);
    check("glitch_frame", u_if.frame_error_o, 0);
    check("glitch_parity", u_if.parity_error_o, 0);
    check("glitch_count", u_if.fifo_count_o, 0);
    check("glitch_busy", u_if.write_busy_o, 0);
    send_frame(8'h96, 0, 0);
    drain();

    // echo disabled: good byte discarded
    set_cfg(15, 0, 0, 0);
    u_if.echo_enable_i = 1'b0;
    send_frame(8'h11, 0, 0);
    repeat (10) @(negedge clk);
    check("noecho_count", u_if.fifo_count_o, 0);
    check("noecho_busy", u_if.write_busy_o, 0);
    u_if.echo_enable_i = 1'b1;
    drain();

    // randomized blocks
    for (int b = 0; b < 4; b++) begin
      set_cfg($urandom_range(3, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 12; k++) begin
        rd = 8'($urandom);
        bp = ($urandom_range(0, 7) == 0);
        bs = ($urandom_range(0, 9) == 0);
        send_frame(rd, bp, bs);
        repeat (6) @(negedge clk);
        check("rnd_frame_flag", u_if.frame_error_o, bs);
        check("rnd_parity_flag", u_if.parity_error_o, !bs && mon_par && bp);
        check("rnd_overrun", u_if.overrun_o, 0);
        if (bs || (mon_par && bp)) clear_flags();
        repeat (2 * (mon_div + 1) + $urandom_range(0, mon_div)) @(negedge clk);
      end
      drain();
    end

    // back-to-back burst into depth-4 FIFO with slower 2-stop TX
    set_cfg(3, 0, 0, 1);
    sub_mode = 1;
    n_sub_rx = 0;
    for (int k = 0; k < 60; k++) send_frame(8'($urandom), 0, 0);
    drain();
    check("burst_overrun", u_if.overrun_o, 1);
    check("burst_some_dropped", n_sub_rx < 60, 1);
    check("burst_enough_echoed", n_sub_rx >= 30, 1);
    sub_mode = 0;
    exp_q.delete();
    clear_flags();

    // reset in the middle of a TX data bit
    set_cfg(15, 0, 0, 0);
    mon_ignore = 1;
    fork
      send_frame(8'h3C, 0, 0);
      begin
        t = 0;
        while (u_if.serial_o !== 1'b0 && t < 1000) begin
          @(negedge clk);
          t++;
        end
        repeat (24) @(negedge clk);
        check("pre_reset_tx_low", u_if.serial_o, 0);
        #2 rst = 1'b1;
        #1;
        check("reset_serial_o", u_if.serial_o, 1);
        check("reset_count", u_if.fifo_count_o, 0);
        check("reset_busy", u_if.write_busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (300) @(negedge clk);
    mon_ignore = 0;
    exp_q.delete();
    send_frame(8'hC3, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
